cmd_ctrl: RTL

CMD_CTRL -- requirements
Module: cmd_ctrl

---
 rtl/cmd_ctrl.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/cmd_ctrl.sv
// cmd_ctrl -- byte-stream command decoder driving a register file, an ALU
// and a TX FIFO.
//
// Ports
//   CLK, RST                   clock, synchronous active-high reset
//   RX_P_DATA, RX_D_VLD        incoming command/operand bytes
//   RF_ADDR, RF_WR_EN, RF_RD_EN, RF_WR_DATA, RF_RD_DATA, RF_RD_VLD
//                              register-file access
//   ALU_FUNC, ALU_EN, ALU_CLK_EN, ALU_OUT, ALU_OUT_VLD
//                              ALU control and result
//   FIFO_WR_DATA, FIFO_WR_INC, FIFO_FULL
//                              TX FIFO write port
//   BUSY                       FSM not idle
//   CMD_ERR                    one-cycle error pulse
//
// state    | meaning
// IDLE     | waiting for an opcode byte
// GET_ADDR | waiting for the address byte (AA/BB/EE)
// GET_DATA | waiting for the write-data byte (AA)
// GET_A    | waiting for operand A, written to RF address 0
// GET_B    | waiting for operand B, written to RF address 1
// GET_FN   | waiting for the ALU function byte
// RF_RD    | RF_RD_EN high for single read
// RF_WAIT  | waiting for RF_RD_VLD of single read
// ALU_RUN  | ALU_EN high, ALU clock enabled
// ALU_WAIT | ALU clock enabled, waiting for ALU_OUT_VLD
// TX_LO    | pushing low result word to FIFO
// TX_HI    | pushing high result word to FIFO
// GET_CNT  | waiting for the burst count byte
// BR_RD    | RF_RD_EN high for one burst word
// BR_WAIT  | waiting for RF_RD_VLD of burst word
// BR_TX    | pushing burst word to FIFO, then next address
module cmd_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int ALU_FUNC_WIDTH = 4
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
   input  logic                      RX_D_VLD,
   output logic [ADDR_WIDTH-1:0]     RF_ADDR,
   output logic                      RF_WR_EN,
   output logic                      RF_RD_EN,
   output logic [DATA_WIDTH-1:0]     RF_WR_DATA,
   input  logic [DATA_WIDTH-1:0]     RF_RD_DATA,
   input  logic                      RF_RD_VLD,
   output logic [ALU_FUNC_WIDTH-1:0] ALU_FUNC,
   output logic                      ALU_EN,
   output logic                      ALU_CLK_EN,
   input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
   input  logic                      ALU_OUT_VLD,
   output logic [DATA_WIDTH-1:0]     FIFO_WR_DATA,
   output logic                      FIFO_WR_INC,
   input  logic                      FIFO_FULL,
   output logic                      BUSY,
   output logic                      CMD_ERR
);

   typedef enum logic [3:0] {
      IDLE, GET_ADDR, GET_DATA, GET_A, GET_B, GET_FN, RF_RD, RF_WAIT,
      ALU_RUN, ALU_WAIT, TX_LO, TX_HI, GET_CNT, BR_RD, BR_WAIT, BR_TX
   } state_t;

   localparam logic [7:0] OP_RF_WR  = 8'hAA;
   localparam logic [7:0] OP_RF_RD  = 8'hBB;
   localparam logic [7:0] OP_ALU_OP = 8'hCC;
   localparam logic [7:0] OP_ALU_NO = 8'hDD;
   localparam logic [7:0] OP_BURST  = 8'hEE;

   state_t                      state, state_nx;
   logic [7:0]                  op_q, op_nx;
   logic [2*DATA_WIDTH-1:0]     result_q, result_nx;
   logic [DATA_WIDTH-1:0]       count_q, count_nx;
   logic [ADDR_WIDTH-1:0]       addr_nx;
   logic [DATA_WIDTH-1:0]       wr_data_nx, fifo_data_nx;
   logic [ALU_FUNC_WIDTH-1:0]   func_nx;
   logic                        wr_en_nx, rd_en_nx, alu_en_nx, clk_en_nx;
   logic                        fifo_inc_nx, err_nx;
   logic                        rx_state, tx_ok;

   // Opcodes occupy the low byte; any set upper bit makes the byte unknown.
   function automatic logic is_op(input logic [DATA_WIDTH-1:0] b, input logic [7:0] op);
      return b == DATA_WIDTH'(op);
   endfunction

   // A write is only issued when no pulse is already in flight, so FIFO_FULL
   // has had a cycle to reflect the previous word before the next decision.
   assign tx_ok    = !FIFO_FULL && !FIFO_WR_INC;
   assign rx_state = state inside {IDLE, GET_ADDR, GET_DATA, GET_A, GET_B, GET_FN, GET_CNT};
   assign BUSY     = (state != IDLE);

   always_comb begin
      state_nx     = state;
      op_nx        = op_q;
      result_nx    = result_q;
      count_nx     = count_q;
      addr_nx      = RF_ADDR;
      wr_data_nx   = RF_WR_DATA;
      fifo_data_nx = FIFO_WR_DATA;
      func_nx      = ALU_FUNC;
      wr_en_nx     = 1'b0;
      fifo_inc_nx  = 1'b0;
      err_nx       = 1'b0;

      case (state)
         IDLE: if (RX_D_VLD) begin
            op_nx = RX_P_DATA[7:0];
            if (is_op(RX_P_DATA, OP_RF_WR) || is_op(RX_P_DATA, OP_RF_RD) ||
                is_op(RX_P_DATA, OP_BURST))
               state_nx = GET_ADDR;
            else if (is_op(RX_P_DATA, OP_ALU_OP))
               state_nx = GET_A;
            else if (is_op(RX_P_DATA, OP_ALU_NO))
               state_nx = GET_FN;
            else
               err_nx = 1'b1;
         end
         GET_ADDR: if (RX_D_VLD) begin
            addr_nx = RX_P_DATA[ADDR_WIDTH-1:0];
            if (op_q == OP_RF_WR)      state_nx = GET_DATA;
            else if (op_q == OP_RF_RD) state_nx = RF_RD;
            else                       state_nx = GET_CNT;
         end
         GET_DATA: if (RX_D_VLD) begin
            wr_data_nx = RX_P_DATA;
            wr_en_nx   = 1'b1;
            state_nx   = IDLE;
         end
         GET_A: if (RX_D_VLD) begin
            addr_nx    = '0;
            wr_data_nx = RX_P_DATA;
            wr_en_nx   = 1'b1;
            state_nx   = GET_B;
         end
         GET_B: if (RX_D_VLD) begin
            addr_nx    = ADDR_WIDTH'(1);
            wr_data_nx = RX_P_DATA;
            wr_en_nx   = 1'b1;
            state_nx   = GET_FN;
         end
         GET_FN: if (RX_D_VLD) begin
            func_nx  = RX_P_DATA[ALU_FUNC_WIDTH-1:0];
            state_nx = ALU_RUN;
         end
         GET_CNT: if (RX_D_VLD) begin
            if (RX_P_DATA == '0) begin
               err_nx   = 1'b1;
               state_nx = IDLE;
            end else begin
               count_nx = RX_P_DATA;
               state_nx = BR_RD;
            end
         end
         RF_RD:   state_nx = RF_WAIT;
         RF_WAIT: if (RF_RD_VLD) begin
            result_nx = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
            state_nx  = TX_LO;
         end
         ALU_RUN:  state_nx = ALU_WAIT;
         ALU_WAIT: if (ALU_OUT_VLD) begin
            result_nx = ALU_OUT;
            state_nx  = TX_LO;
         end
         TX_LO: if (tx_ok) begin
            fifo_data_nx = result_q[DATA_WIDTH-1:0];
            fifo_inc_nx  = 1'b1;
            state_nx     = (op_q == OP_RF_RD) ? IDLE : TX_HI;
         end
         TX_HI: if (tx_ok) begin
            fifo_data_nx = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
            fifo_inc_nx  = 1'b1;
            state_nx     = IDLE;
         end
         BR_RD:   state_nx = BR_WAIT;
         BR_WAIT: if (RF_RD_VLD) begin
            result_nx = {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
            state_nx  = BR_TX;
         end
         BR_TX: if (tx_ok) begin
            fifo_data_nx = result_q[DATA_WIDTH-1:0];
            fifo_inc_nx  = 1'b1;
            addr_nx      = RF_ADDR + ADDR_WIDTH'(1);
            count_nx     = count_q - DATA_WIDTH'(1);
            state_nx     = (count_q == DATA_WIDTH'(1)) ? IDLE : BR_RD;
         end
         default: state_nx = IDLE;
      endcase

      if (RX_D_VLD && !rx_state)
         err_nx = 1'b1;

      // Strobes tied to a state are registered from the next state so they
      // are high exactly while the FSM sits in that state.
      rd_en_nx  = (state_nx == RF_RD) || (state_nx == BR_RD);
      alu_en_nx = (state_nx == ALU_RUN);
      clk_en_nx = (state_nx == ALU_RUN) || (state_nx == ALU_WAIT);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         op_q         <= '0;
         result_q     <= '0;
         count_q      <= '0;
         RF_ADDR      <= '0;
         RF_WR_DATA   <= '0;
         RF_WR_EN     <= 1'b0;
         RF_RD_EN     <= 1'b0;
         ALU_FUNC     <= '0;
         ALU_EN       <= 1'b0;
         ALU_CLK_EN   <= 1'b0;
         FIFO_WR_DATA <= '0;
         FIFO_WR_INC  <= 1'b0;
         CMD_ERR      <= 1'b0;
      end else begin
         state        <= state_nx;
         op_q         <= op_nx;
         result_q     <= result_nx;
         count_q      <= count_nx;
         RF_ADDR      <= addr_nx;
         RF_WR_DATA   <= wr_data_nx;
         RF_WR_EN     <= wr_en_nx;
         RF_RD_EN     <= rd_en_nx;
         ALU_FUNC     <= func_nx;
         ALU_EN       <= alu_en_nx;
         ALU_CLK_EN   <= clk_en_nx;
         FIFO_WR_DATA <= fifo_data_nx;
         FIFO_WR_INC  <= fifo_inc_nx;
         CMD_ERR      <= err_nx;
      end
   end

endmodule
